// File: rtl/axi4_sram_banked_ctrl.sv
// Banked SRAM controller: valid/ready requests decoded onto NUM_BANKS byte-masked regfile banks.
// Latency: 2 cycles accept-to-response. Backpressure: credit-based; req_ready_o drops when the FIFO plus stage 1 are full.

module tech_regfile_bm #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 512
) (
   input  logic                        clk,
   input  logic                        en,
   input  logic                        wen,
   input  logic [$clog2(DEPTH)-1:0]    addr,
   input  logic [DATA_WIDTH/8-1:0]     bm,
   input  logic [DATA_WIDTH-1:0]       wr_dat,
   output logic [DATA_WIDTH-1:0]       rd_dat
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (wen) begin
            for (int i = 0; i < DATA_WIDTH/8; i++) begin
               if (bm[i]) mem[addr][8*i +: 8] <= wr_dat[8*i +: 8];
            end
         end else begin
            rd_dat <= mem[addr];
         end
      end
   end
endmodule

module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_vld,
   input  logic [WIDTH-1:0]             push_dat,
   input  logic                         pop_rdy,
   output logic                         head_vld,
   output logic [WIDTH-1:0]             head_dat,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             push, pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign head_vld = (count != '0);
   assign pop      = head_vld && pop_rdy;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push     = push_vld && ((count < CW'(DEPTH)) || pop);
   assign head_dat = head_vld ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_next(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end
endmodule

module axi4_sram_banked_ctrl #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    WORD_DEPTH = 512,
   parameter int                    NUM_BANKS  = 4,
   parameter int                    INTERLEAVE = 0,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h0F00_0000,
   parameter int                    RSP_DEPTH  = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH/8-1:0] req_bm_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    rsp_we_o
);
   localparam int BYTE_SH = $clog2(DATA_WIDTH/8);
   localparam int ROW_W   = $clog2(WORD_DEPTH);
   localparam int BANK_SH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
   localparam int BANK_W  = (NUM_BANKS > 1) ? BANK_SH : 1;
   localparam int CW      = $clog2(RSP_DEPTH+1);
   localparam int RSP_W   = DATA_WIDTH + 2;
   localparam logic [ADDR_WIDTH-1:0] TOTAL_WORDS = ADDR_WIDTH'(NUM_BANKS*WORD_DEPTH);

   logic [ADDR_WIDTH-1:0] off, widx;
   logic [BANK_W-1:0]     dec_bank;
   logic [ROW_W-1:0]      bank_row;
   logic                  dec_err, accept;
   logic [NUM_BANKS-1:0]  bank_en;
   logic [DATA_WIDTH-1:0] bank_rdat [NUM_BANKS];

   logic                  s1_vld, s1_we, s1_err;
   logic [BANK_W-1:0]     s1_bank;
   logic [DATA_WIDTH-1:0] s1_rdat, s1_rsp_dat;
   logic [RSP_W-1:0]      fifo_head;
   logic [CW-1:0]         fifo_cnt;

   always_comb begin
      off      = req_addr_i - BASE_ADDR;
      widx     = off >> BYTE_SH;
      dec_err  = (req_addr_i < BASE_ADDR) || (widx >= TOTAL_WORDS);
      dec_bank = '0;
      bank_row = '0;
      if (INTERLEAVE != 0) begin
         dec_bank = widx[BANK_W-1:0];
         bank_row = widx[BANK_SH +: ROW_W];
      end else begin
         dec_bank = widx[ROW_W +: BANK_W];
         bank_row = widx[ROW_W-1:0];
      end
      if (NUM_BANKS == 1) dec_bank = '0;
   end

   // Credit check depends only on registered state, so there is no path from rsp_ready_i.
   assign req_ready_o = !rst_i && (({1'b0, fifo_cnt} + (CW+1)'(s1_vld)) < (CW+1)'(RSP_DEPTH));
   assign accept      = req_valid_i && req_ready_o;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign bank_en[b] = accept && !dec_err && (dec_bank == BANK_W'(b));
      tech_regfile_bm #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(WORD_DEPTH)) u_bank (
         .clk    (clk_i),
         .en     (bank_en[b]),
         .wen    (req_we_i),
         .addr   (bank_row),
         .bm     (req_bm_i),
         .wr_dat (req_wdata_i),
         .rd_dat (bank_rdat[b])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_vld  <= 1'b0;
         s1_we   <= 1'b0;
         s1_err  <= 1'b0;
         s1_bank <= '0;
      end else begin
         s1_vld  <= accept;
         s1_we   <= req_we_i;
         s1_err  <= dec_err;
         s1_bank <= dec_bank;
      end
   end

   always_comb begin
      s1_rdat = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (s1_bank == BANK_W'(b)) s1_rdat = bank_rdat[b];
      end
      s1_rsp_dat = (s1_we || s1_err) ? '0 : s1_rdat;
   end

   fifo_sync #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .push_vld (s1_vld),
      .push_dat ({s1_rsp_dat, s1_err, s1_we}),
      .pop_rdy  (rsp_ready_i),
      .head_vld (rsp_valid_o),
      .head_dat (fifo_head),
      .count    (fifo_cnt)
   );

   assign rsp_rdata_o = fifo_head[RSP_W-1:2];
   assign rsp_err_o   = fifo_head[1];
   assign rsp_we_o    = fifo_head[0];
endmodule

// File: tb/tb_axi4_sram_banked_ctrl.sv
// Directed bench: contiguous instance is the main DUT, an interleaved twin shares its request inputs.
module tb_axi4_sram_banked_ctrl;
   localparam logic [31:0] BASE = 32'h0F00_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_bm;
   logic        req_ready, rsp_valid, rsp_err, rsp_we;
   logic [31:0] rsp_rdata;
   logic        il_req_ready, il_rsp_valid, il_rsp_err, il_rsp_we;
   logic [31:0] il_rsp_rdata;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axi4_sram_banked_ctrl #(.INTERLEAVE(0)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_bm_i(req_bm), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .rsp_we_o(rsp_we)
   );

   axi4_sram_banked_ctrl #(.INTERLEAVE(1)) dut_il (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(il_req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_bm_i(req_bm), .req_wdata_i(req_wdata),
      .rsp_valid_o(il_rsp_valid), .rsp_ready_i(1'b1), .rsp_rdata_o(il_rsp_rdata),
      .rsp_err_o(il_rsp_err), .rsp_we_o(il_rsp_we)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge; returns just after the falling edge that follows the accept.
   task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] bm, input logic [31:0] wd);
      int t;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_bm = bm; req_wdata = wd;
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) chk("send_timeout", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic get_rsp(input string tag, input logic [31:0] rd, input logic err, input logic we);
      int t;
      t = 0;
      while (!rsp_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(rd));
      chk({tag, "_err"},   64'(rsp_err),   64'(err));
      chk({tag, "_we"},    64'(rsp_we),    64'(we));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      int acc, got, stall;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_bm = '0; req_wdata = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_rsp_err",   64'(rsp_err),   64'd0);
      chk("rst_rsp_we",    64'(rsp_we),    64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(req_ready), 64'd1);

      // basic write/read and 2-cycle latency
      send(1'b1, BASE, 4'hF, 32'hDEAD_BEEF);
      get_rsp("wr0", 32'h0, 1'b0, 1'b1);
      send(1'b0, BASE, 4'h0, 32'h0);
      chk("lat_t1_valid", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      chk("lat_t2_valid", 64'(rsp_valid), 64'd1);
      get_rsp("rd0", 32'hDEAD_BEEF, 1'b0, 1'b0);

      // bank decode, contiguous vs interleaved
      req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h800; req_bm = 4'hF; req_wdata = 32'h0BAD_0800;
      #1;
      chk("c800_en",  64'(dut.bank_en),     64'h2);
      chk("c800_row", 64'(dut.bank_row),    64'd0);
      chk("i800_en",  64'(dut_il.bank_en),  64'h1);
      chk("i800_row", 64'(dut_il.bank_row), 64'd128);
      @(negedge clk);
      req_valid = 1'b0;
      get_rsp("w800", 32'h0, 1'b0, 1'b1);
      req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h4; req_wdata = 32'h0BAD_0004;
      #1;
      chk("c004_en",  64'(dut.bank_en),     64'h1);
      chk("c004_row", 64'(dut.bank_row),    64'd1);
      chk("i004_en",  64'(dut_il.bank_en),  64'h2);
      chk("i004_row", 64'(dut_il.bank_row), 64'd0);
      @(negedge clk);
      req_valid = 1'b0;
      get_rsp("w004", 32'h0, 1'b0, 1'b1);

      // byte mask merge
      send(1'b1, BASE + 32'h10, 4'hF, 32'h1122_3344);
      get_rsp("wm_full", 32'h0, 1'b0, 1'b1);
      send(1'b1, BASE + 32'h10, 4'b0101, 32'hAABB_CCDD);
      get_rsp("wm_part", 32'h0, 1'b0, 1'b1);
      send(1'b0, BASE + 32'h10, 4'h0, 32'h0);
      get_rsp("rd_mask", 32'h11BB_33DD, 1'b0, 1'b0);

      // read-after-write on consecutive cycles
      send(1'b1, BASE + 32'h20, 4'hF, 32'hCAFE_F00D);
      send(1'b0, BASE + 32'h20, 4'h0, 32'h0);
      get_rsp("raw_w", 32'h0, 1'b0, 1'b1);
      get_rsp("raw_r", 32'hCAFE_F00D, 1'b0, 1'b0);

      // out-of-range
      req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 32'h2000;
      #1;
      chk("oor_hi_en", 64'(dut.bank_en), 64'h0);
      @(negedge clk);
      req_valid = 1'b0;
      get_rsp("oor_hi", 32'h0, 1'b1, 1'b0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = BASE - 32'h4;
      #1;
      chk("oor_lo_en", 64'(dut.bank_en), 64'h0);
      @(negedge clk);
      req_valid = 1'b0;
      get_rsp("oor_lo", 32'h0, 1'b1, 1'b0);
      send(1'b1, BASE + 32'h2000, 4'hF, 32'hFFFF_FFFF);
      get_rsp("oor_wr", 32'h0, 1'b1, 1'b1);

      // backpressure: preload 10 words, then stream reads with rsp_ready low
      for (int i = 0; i < 10; i++) begin
         send(1'b1, BASE + 32'h100 + 32'(4*i), 4'hF, 32'h1000 + 32'(i));
         get_rsp("bp_pre", 32'h0, 1'b0, 1'b1);
      end
      acc = 0;
      rsp_ready = 1'b0;
      req_we = 1'b0;
      for (int c = 0; c < 10; c++) begin
         req_valid = 1'b1;
         req_addr = BASE + 32'h100 + 32'(4*acc);
         if (req_ready) acc++;
         @(negedge clk);
      end
      chk("bp_accepted", 64'(acc), 64'd4);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("bp_hold_rdata", 64'(rsp_rdata), 64'h1000);
      got = 0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 80 && got < 10; c++) begin
         if (rsp_valid) begin
            chk("bp_rdata", 64'(rsp_rdata), 64'h1000 + 64'(got));
            got++;
         end
         req_valid = (acc < 10);
         req_addr = BASE + 32'h100 + 32'(4*acc);
         if (req_valid && req_ready) acc++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("bp_accepted_all", 64'(acc), 64'd10);
      chk("bp_got_all", 64'(got), 64'd10);
      repeat (3) @(negedge clk);
      chk("bp_no_extra", 64'(rsp_valid), 64'd0);

      // sustained throughput with rsp_ready high
      acc = 0; got = 0; stall = 0;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if (rsp_valid) begin
            chk("sus_rdata", 64'(rsp_rdata), 64'h1000 + 64'(got));
            got++;
         end
         req_valid = (acc < 8);
         req_addr = BASE + 32'h100 + 32'(4*acc);
         if (req_valid && req_ready) acc++;
         else if (req_valid) stall++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("sus_stalls", 64'(stall), 64'd0);
      chk("sus_got", 64'(got), 64'd8);

      // reset with a write response queued and a read in stage 1
      send(1'b1, BASE + 32'h40, 4'hF, 32'h5A5A_5A5A);
      send(1'b0, BASE + 32'h40, 4'h0, 32'h0);
      rst = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h40; req_bm = 4'hF; req_wdata = 32'hFFFF_FFFF;
      #1;
      chk("mid_rst_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_rdata", 64'(rsp_rdata), 64'd0);
      chk("mid_rst_err",   64'(rsp_err),   64'd0);
      chk("mid_rst_we",    64'(rsp_we),    64'd0);
      req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst2_valid", 64'(rsp_valid), 64'd0);
      send(1'b0, BASE + 32'h40, 4'h0, 32'h0);
      get_rsp("rst_keep40", 32'h5A5A_5A5A, 1'b0, 1'b0);
      send(1'b0, BASE, 4'h0, 32'h0);
      get_rsp("rst_keep0", 32'hDEAD_BEEF, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
